// File: rtl/pj_frame_serializer.sv
// pj_frame_serializer: snapshots a 2x4x5 frame of 4-state time elements and streams them sanitised over valid/ready
module pj_frame_serializer #(
  parameter int ROWS = 2,
  parameter int COLS = 4,
  parameter int DEPTH = 5,
  parameter int W = 64,
  localparam int N = ROWS * COLS * DEPTH,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N*W-1:0] frame_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_idx,
  output logic           out_xz,
  output logic           out_last,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  xz_count
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, DONE = 2'd3;
  logic [1:0] st;
  logic [IW-1:0] idx;
  logic [CW-1:0] xc;
  logic [W-1:0] mem [N];
  logic [N-1:0] flg;
  logic [W-1:0] cd [N];
  logic [N-1:0] cf;
  logic send;
  // Only a definite 1 survives sanitising; anything that is neither 0 nor 1 raises the flag.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cf[i] = 1'b0;
      for (int b = 0; b < W; b++) begin
        cd[i][b] = frame_in[i*W+b] === 1'b1;
        cf[i] = cf[i] | !(frame_in[i*W+b] === 1'b0 || frame_in[i*W+b] === 1'b1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      idx <= '0;
      xc <= '0;
      flg <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (st == IDLE && start) begin
      for (int i = 0; i < N; i++) mem[i] <= cd[i];
      flg <= cf;
      idx <= '0;
      xc <= '0;
      st <= LOAD;
    end else if (st == LOAD) begin
      st <= SEND;
    end else if (st == SEND && out_ready) begin
      xc <= xc + CW'(flg[idx]);
      if (idx == IW'(N - 1)) st <= DONE;
      else idx <= idx + IW'(1);
    end else if (st == DONE) begin
      st <= IDLE;
    end
  end
  assign send = st == SEND;
  assign out_valid = send;
  assign out_data = send ? mem[idx] : '0;
  assign out_idx = send ? idx : '0;
  assign out_xz = send & flg[idx];
  assign out_last = send && idx == IW'(N - 1);
  assign busy = st != IDLE;
  assign done = st == DONE;
  assign xz_count = xc;
endmodule
